// File: rtl/spi_mem_bridge.sv
// SPI slave bridging serial frames to an internal word memory and a TX FIFO.
// Define SPI_MEM_ERR_FLAGS_EN to add sticky FIFO overflow/underflow flags.
module spi_mem_bridge #(
    parameter int DATA_W     = 8,
    parameter int MEM_DEPTH  = 2**DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SS_n,
    input  logic                        MOSI,
    output logic                        MISO,
    input  logic                        apb_mode,
    input  logic [DATA_W-1:0]           tx_wdata,
    input  logic                        tx_wr,
    output logic                        tx_full,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic [DATA_W+1:0]           rx_data,
    output logic                        rx_valid
`ifdef SPI_MEM_ERR_FLAGS_EN
    ,
    output logic                        err_ovf,
    output logic                        err_udf
`endif
);

    localparam int FW  = DATA_W + 2;
    localparam int CW  = $clog2(FW + 1);
    localparam int TCW = $clog2(DATA_W);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA
    } state_t;

    state_t              state;
    logic [CW-1:0]       bit_cnt;
    logic [FW-2:0]       shreg;
    logic [DATA_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   rd_addr;
    logic                rd_addr_valid;
    logic                fetch_pend;
    logic [DATA_W-2:0]   tx_sh;
    logic [TCW-1:0]      tx_cnt;

    logic [DATA_W-1:0]   mem  [MEM_DEPTH];
    logic [DATA_W-1:0]   fifo [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    logic [FW-1:0]       frame;
    logic [1:0]          cmd;
    logic [DATA_W-1:0]   payload;
    logic                in_frame;
    logic                frame_last;
    logic                wr_ok;
    logic                rd_ok;
    logic                mem_we;
    logic                fetch;
    logic                pop;
    logic                pop_ok;
    logic                push;
    logic                fifo_empty;
    logic [DATA_W-1:0]   rd_word;

    // The final bit is combined with the shift register so the frame
    // can be decoded on the same edge that samples it.
    assign frame      = {shreg, MOSI};
    assign cmd        = frame[FW-1:FW-2];
    assign payload    = frame[DATA_W-1:0];
    assign in_frame   = (state == WRITE) || (state == READ_ADD) ||
                        (state == READ_DATA);
    assign frame_last = !SS_n && in_frame && (bit_cnt == CW'(FW - 1));

    assign wr_ok  = {1'b0, wr_addr} < (DATA_W + 1)'(MEM_DEPTH);
    assign rd_ok  = {1'b0, rd_addr} < (DATA_W + 1)'(MEM_DEPTH);
    assign mem_we = !rst && frame_last && (cmd == 2'b01) && wr_ok;

    assign fetch      = fetch_pend && !SS_n;
    assign pop        = fetch && apb_mode;
    assign fifo_empty = (tx_level == '0);
    assign tx_full    = (tx_level == (PW + 1)'(FIFO_DEPTH));
    assign push       = tx_wr && !tx_full;
    assign pop_ok     = pop && !fifo_empty;

    always_comb begin
        rd_word = '0;
        if (apb_mode) begin
            if (!fifo_empty) rd_word = fifo[rd_ptr];
        end else if (rd_ok) begin
            rd_word = mem[rd_addr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr[AW-1:0]] <= payload;
        if (push && !rst) fifo[wr_ptr] <= tx_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop_ok)
                tx_level <= tx_level + (PW + 1)'(1);
            else if (pop_ok && !push)
                tx_level <= tx_level - (PW + 1)'(1);
        end
    end

`ifdef SPI_MEM_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (tx_wr && tx_full) err_ovf <= 1'b1;
            if (pop && fifo_empty) err_udf <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            rd_addr_valid <= 1'b0;
            fetch_pend    <= 1'b0;
            tx_sh         <= '0;
            tx_cnt        <= '0;
            MISO          <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                fetch_pend <= 1'b0;
                tx_cnt     <= '0;
                MISO       <= 1'b0;
            end else begin
                if (fetch) begin
                    MISO          <= rd_word[DATA_W-1];
                    tx_sh         <= rd_word[DATA_W-2:0];
                    tx_cnt        <= TCW'(DATA_W - 1);
                    fetch_pend    <= 1'b0;
                    rd_addr_valid <= 1'b0;
                end else if (tx_cnt != '0) begin
                    MISO   <= tx_sh[DATA_W-2];
                    tx_sh  <= {tx_sh[DATA_W-3:0], 1'b0};
                    tx_cnt <= tx_cnt - TCW'(1);
                end else begin
                    MISO <= 1'b0;
                end

                unique case (state)
                    IDLE: begin
                        state   <= CHK_CMD;
                        bit_cnt <= '0;
                    end
                    CHK_CMD: begin
                        if (!MOSI)
                            state <= WRITE;
                        else if (rd_addr_valid)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt < CW'(FW)) begin
                            shreg   <= {shreg[FW-3:0], MOSI};
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                        if (frame_last) begin
                            rx_data  <= frame;
                            rx_valid <= 1'b1;
                            unique case (cmd)
                                2'b00: wr_addr <= payload;
                                2'b10: begin
                                    rd_addr       <= payload;
                                    rd_addr_valid <= 1'b1;
                                end
                                2'b11: begin
                                    if (state == READ_DATA)
                                        fetch_pend <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_mem_bridge.md
SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data and address width in bits (minimum 4).
REQ-002 SHALL have parameter MEM_DEPTH, default 2**DATA_W: number of internal memory words (at most 2**DATA_W).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: TX FIFO entries (power of two, at least 2).
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk (input, 1, rising-edge clock, also the SPI bit clock) and rst (input, 1, asynchronous active-high reset).
REQ-005 SHALL have port SS_n, input, 1 bit: active-low frame select.
REQ-006 SHALL have port MOSI, input, 1 bit: serial in, MSB first.
REQ-007 SHALL have port MISO, output, 1 bit: serial out, MSB first.
REQ-008 SHALL have port apb_mode, input, 1 bit: 1 means read data comes from the TX FIFO; 0 means it comes from memory.
REQ-009 SHALL have port tx_wdata, input, DATA_W bits: FIFO write data.
REQ-010 SHALL have port tx_wr, input, 1 bit: FIFO push strobe.
REQ-011 SHALL have port tx_full, output, 1 bit: FIFO full.
REQ-012 SHALL have port tx_level, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-013 SHALL have port rx_data, output, DATA_W+2 bits: last complete received frame.
REQ-014 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.

Function
REQ-015 SHALL implement the following FSM.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Any state goes to IDLE whenever SS_n=1 at a clk edge.
REQ-016 In IDLE, SS_n=0 SHALL cause a transition to CHK_CMD with no bit sampled.
REQ-017 In CHK_CMD, the sampled MOSI SHALL select the next state.
- MOSI=0: go to WRITE.
- MOSI=1: go to READ_DATA if rd_addr_valid=1, else go to READ_ADD.
REQ-018 In WRITE and READ_ADD, the block SHALL shift in DATA_W+2 bits MSB first, one per cycle, then pulse rx_valid for exactly one cycle with rx_data holding the frame.
REQ-019 rx_data[DATA_W+1:DATA_W] SHALL be decoded as follows.
- 00: latch wr_addr.
- 01: write mem[wr_addr].
- 10: latch rd_addr and set rd_addr_valid.
- 11: no action in WRITE.
REQ-020 In READ_DATA, the block SHALL shift in DATA_W+2 bits; command 11 SHALL then fetch the read word one cycle later.
- apb_mode=0: mem[rd_addr].
- apb_mode=1: FIFO head, popped.
- The word SHALL be driven on MISO MSB first over the next DATA_W cycles.
- rd_addr_valid SHALL be cleared.
REQ-021 Writes to an address >= MEM_DEPTH SHALL be ignored; reads from such an address SHALL return 0.
REQ-022 If SS_n rises mid-frame, the partial frame SHALL be discarded: no rx_valid, no memory or address update, no FIFO pop, MISO=0.
REQ-023 MISO SHALL be 0 whenever the block is not shifting read data.
REQ-024 tx_wr with tx_full=0 SHALL push tx_wdata; tx_wr with tx_full=1 SHALL be ignored.
REQ-025 A simultaneous push and pop SHALL leave tx_level unchanged, and the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 A pop with the FIFO empty SHALL shift out all zeros and leave tx_level at 0.

Reset
REQ-027 On rst=1, the block SHALL asynchronously set:
- FSM to IDLE.
- MISO, rx_valid, tx_full, tx_level and rx_data to 0.
- wr_addr, rd_addr and rd_addr_valid to 0.
- FIFO pointers to 0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no side effects.

Configuration
REQ-030 With macro SPI_MEM_ERR_FLAGS_EN defined, the block SHALL add outputs err_ovf (sticky 1 on a push while full) and err_udf (sticky 1 on a pop while empty).
- Both SHALL be cleared only by rst.
REQ-031 Without SPI_MEM_ERR_FLAGS_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Bench SHALL cover write address then write data: DATA_W=8, frames 00_0x12 then 01_0xA5 -> two rx_valid pulses, and mem[0x12]=0xA5.
REQ-033 Bench SHALL cover memory read-back, apb_mode=0: frames 10_0x12 then 11_0x00 -> MISO shifts 1010_0101 MSB first, starting 1 cycle after the last bit.
REQ-034 Bench SHALL cover FIFO mode: apb_mode=1, push 0x3C and 0x7E, then two read frame pairs -> MISO gives 0x3C then 0x7E, tx_level goes 2->1->0.
REQ-035 Bench SHALL cover an aborted frame: SS_n rises after 5 bits of a 01 frame -> no rx_valid, the memory word is unchanged, FSM returns to IDLE.
REQ-036 Bench SHALL cover full/empty: FIFO_DEPTH=4 with 5 pushes -> tx_full=1, tx_level=4, err_ovf=1 (macro on); read with FIFO empty -> MISO all 0, err_udf=1.
REQ-037 Bench SHALL cover reset mid-read: rst pulsed during MISO shifting -> MISO=0 immediately, rd_addr_valid=0, next frame decodes normally.
